// File: rtl/systolic_pkg.sv
// Shared systolic-array definitions: default result geometry and the
// output-buffer drain state machine encoding.
package systolic_pkg;

  localparam int OB_DEPTH  = 16;
  localparam int OB_DATA_W = 32;
  localparam int OB_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    DONE
  } drain_state_t;

endpackage

// File: rtl/op_buffer_mem.sv
// Result storage: one write port, one registered read port.
// Only the read register is reset; the array contents are left as-is.
module op_buffer_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-edge write to rd_addr is not seen by this read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/output_buffer.sv
// Accumulator result buffer: random-access word writes, streamed drain of a
// circular entry range with ready/valid handshake and per-entry freshness flags.
module output_buffer
  import systolic_pkg::*;
#(
  parameter int DEPTH  = OB_DEPTH,
  parameter int DATA_W = OB_DATA_W,
  parameter int ADDR_W = OB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] output_data,
  input  logic [ADDR_W-1:0] output_buffer_addr,
  input  logic              output_buffer_enable,
  input  logic              drain_start,
  input  logic [ADDR_W-1:0] drain_base,
  input  logic [ADDR_W:0]   drain_len,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_stale,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              drain_busy,
  output logic              drain_done,
  output logic [DEPTH-1:0]  entry_valid
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  drain_state_t      state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   len_clamped;
  logic              xfer;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic              wr_hit_raddr;
  logic              wr_hit_cur;
  logic              fetched_dirty;
  logic [DEPTH-1:0]  ev_next;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + 1'b1;
  endfunction

  op_buffer_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (output_buffer_enable),
    .wr_addr (output_buffer_addr),
    .wr_data (output_data),
    .rd_en   (mem_re),
    .rd_addr (mem_raddr),
    .rd_data (rd_data)
  );

  // The memory read register doubles as the presentation register: the next
  // word is read ahead on the same edge the current one is accepted.
  always_comb begin
    xfer         = (state == STREAM) && rd_valid && rd_ready;
    mem_raddr    = (state == FETCH) ? base_q : next_addr(rd_addr);
    mem_re       = (state == FETCH) || (xfer && (remaining != LEN_ONE));
    wr_hit_raddr = output_buffer_enable && (output_buffer_addr == mem_raddr);
    wr_hit_cur   = output_buffer_enable && (output_buffer_addr == rd_addr);
    len_clamped  = (drain_len > LEN_MAX) ? LEN_MAX : drain_len;
  end

  // An entry rewritten after its word was fetched holds undrained data, so
  // the transfer of the older word must not clear its flag.
  always_comb begin
    ev_next = entry_valid;
    if (xfer && !fetched_dirty) ev_next[rd_addr] = 1'b0;
    if (output_buffer_enable)   ev_next[output_buffer_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      base_q        <= '0;
      remaining     <= '0;
      rd_addr       <= '0;
      rd_stale      <= 1'b0;
      rd_valid      <= 1'b0;
      drain_busy    <= 1'b0;
      drain_done    <= 1'b0;
      fetched_dirty <= 1'b0;
      entry_valid   <= '0;
    end else begin
      entry_valid <= ev_next;

      if (mem_re) begin
        rd_addr       <= mem_raddr;
        rd_stale      <= ~entry_valid[mem_raddr];
        fetched_dirty <= wr_hit_raddr;
      end else if (rd_valid && wr_hit_cur) begin
        fetched_dirty <= 1'b1;
      end

      case (state)
        IDLE: begin
          drain_done <= 1'b0;
          if (drain_start) begin
            base_q     <= drain_base;
            remaining  <= len_clamped;
            drain_busy <= 1'b1;
            if (len_clamped != '0) begin
              state <= FETCH;
            end else begin
              state      <= DONE;
              drain_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          state    <= STREAM;
          rd_valid <= 1'b1;
        end
        STREAM: begin
          if (xfer) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_ONE) begin
              state      <= DONE;
              rd_valid   <= 1'b0;
              drain_done <= 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          drain_done <= 1'b0;
          drain_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          rd_valid   <= 1'b0;
          drain_busy <= 1'b0;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
